// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, Funct encodings, the ID/EX
// control bundle and its bubble value, and a saturating 8-bit increment.
package pipeline_pkg;

  localparam int DATA_W     = 16;
  localparam int FUNCT_W    = 3;
  localparam int REG_ADDR_W = 3;

  localparam logic [FUNCT_W-1:0] FUNCT_LOAD  = 3'b001;
  localparam logic [FUNCT_W-1:0] FUNCT_STORE = 3'b010;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD   = 3'b011;
  localparam logic [FUNCT_W-1:0] FUNCT_NOT   = 3'b100;

  typedef struct packed {
    logic               valid;
    logic               alu_op;
    logic [FUNCT_W-1:0] funct;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
  } ctrl_t;

  // ALUOp=0 is decoded downstream as a Nop, so an all-zero bundle is a bubble.
  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// Parameterised-width register with synchronous clear (to a given value)
// taking priority over a load enable.
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] clr_val,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] field_d;
  logic [W-1:0] field_q;

  always_comb begin
    field_d = field_q;
    if (clr) begin
      field_d = clr_val;
    end else if (en) begin
      field_d = d;
    end
  end

  always_ff @(posedge clk) begin
    field_q <= field_d;
  end

  assign q = field_q;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall (hold) and flush (bubble) support and a
// saturating count of bubbles inserted since reset.
module id_ex_register
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = pipeline_pkg::DATA_W,
  parameter int REG_ADDR_W = pipeline_pkg::REG_ADDR_W,
  parameter int FUNCT_W    = pipeline_pkg::FUNCT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  ValidIn,
  input  logic                  ALUOpIn,
  input  logic [FUNCT_W-1:0]    FunctIn,
  input  logic                  RegWriteIn,
  input  logic                  MemReadIn,
  input  logic                  MemWriteIn,
  input  logic                  MemToRegIn,
  input  logic [DATA_W-1:0]     ReadData1In,
  input  logic [DATA_W-1:0]     ReadData2In,
  input  logic [DATA_W-1:0]     ImmIn,
  input  logic [REG_ADDR_W-1:0] RdIn,
  output logic                  ValidOut,
  output logic                  ALUOpOut,
  output logic [FUNCT_W-1:0]    FunctOut,
  output logic                  RegWriteOut,
  output logic                  MemReadOut,
  output logic                  MemWriteOut,
  output logic                  MemToRegOut,
  output logic [DATA_W-1:0]     ReadData1Out,
  output logic [DATA_W-1:0]     ReadData2Out,
  output logic [DATA_W-1:0]     ImmOut,
  output logic [REG_ADDR_W-1:0] RdOut,
  output logic [7:0]            BubbleCount
);

  localparam int DBUS_W = 3 * DATA_W + REG_ADDR_W;

  ctrl_t             ctrl_in;
  ctrl_t             ctrl_load;
  ctrl_t             ctrl_out;
  logic [DBUS_W-1:0] data_in;
  logic [DBUS_W-1:0] data_out;
  logic              clr;
  logic              load_en;
  logic [7:0]        bubble_cnt_d;
  logic [7:0]        bubble_cnt_q;

  assign clr     = rst | Flush;
  assign load_en = ~Stall;

  always_comb begin
    ctrl_in            = CTRL_BUBBLE;
    ctrl_in.valid      = ValidIn;
    ctrl_in.alu_op     = ALUOpIn;
    ctrl_in.funct      = FunctIn;
    ctrl_in.reg_write  = RegWriteIn;
    ctrl_in.mem_read   = MemReadIn;
    ctrl_in.mem_write  = MemWriteIn;
    ctrl_in.mem_to_reg = MemToRegIn;
    // An invalid slot still carries its data; only the controls are neutralised.
    ctrl_load = ValidIn ? ctrl_in : CTRL_BUBBLE;
  end

  assign data_in = {ReadData1In, ReadData2In, ImmIn, RdIn};

  pipe_field_reg #(.W($bits(ctrl_t))) u_ctrl_reg (
    .clk     (clk),
    .clr     (clr),
    .clr_val (CTRL_BUBBLE),
    .en      (load_en),
    .d       (ctrl_load),
    .q       (ctrl_out)
  );

  pipe_field_reg #(.W(DBUS_W)) u_data_reg (
    .clk     (clk),
    .clr     (clr),
    .clr_val ({DBUS_W{1'b0}}),
    .en      (load_en),
    .d       (data_in),
    .q       (data_out)
  );

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (Flush || (!Stall && !ValidIn)) begin
      bubble_cnt_d = sat_inc8(bubble_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= 8'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ValidOut     = ctrl_out.valid;
  assign ALUOpOut     = ctrl_out.alu_op;
  assign FunctOut     = ctrl_out.funct;
  assign RegWriteOut  = ctrl_out.reg_write;
  assign MemReadOut   = ctrl_out.mem_read;
  assign MemWriteOut  = ctrl_out.mem_write;
  assign MemToRegOut  = ctrl_out.mem_to_reg;
  assign ReadData1Out = data_out[DBUS_W-1 -: DATA_W];
  assign ReadData2Out = data_out[DBUS_W-DATA_W-1 -: DATA_W];
  assign ImmOut       = data_out[REG_ADDR_W+DATA_W-1 -: DATA_W];
  assign RdOut        = data_out[REG_ADDR_W-1:0];
  assign BubbleCount  = bubble_cnt_q;

endmodule

// File: doc/id_ex_register.md
Name: id_ex_register

Overview:
- Pipeline register between Decode (ID) and Execute (EX) in the 5-stage pipeline.
- Captures decoded control bits (ALUOp, Funct, memory and write-back controls), operand data, immediate and destination register each cycle.
- Presents them to the EX stage. ALUOp/Funct outputs feed the ALU control decoder directly.
- Supports stall (hold) and flush (bubble insertion) for the hazard unit. A bubble drives ALUOp=0, which the decoder turns into a Nop.

Parameters:
- DATA_W, 16, width of operand and immediate data.
- REG_ADDR_W, 3, width of register-file address.
- FUNCT_W, 3, width of Funct field.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- Stall  in  1  hold all outputs this cycle.
- Flush  in  1  load a bubble this cycle.
- ValidIn  in  1  ID stage holds a real instruction.
- ALUOpIn  in  1  ALU-op class from decoder.
- FunctIn  in  FUNCT_W  function field.
- RegWriteIn  in  1  write-back enable.
- MemReadIn  in  1  load.
- MemWriteIn  in  1  store.
- MemToRegIn  in  1  write-back source select.
- ReadData1In  in  DATA_W  source operand 1.
- ReadData2In  in  DATA_W  source operand 2.
- ImmIn  in  DATA_W  sign-extended immediate.
- RdIn  in  REG_ADDR_W  destination register.
- ValidOut, ALUOpOut, FunctOut, RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut, ReadData1Out, ReadData2Out, ImmOut, RdOut  out  widths as inputs  registered copies.
- BubbleCount  out  8  number of bubbles inserted since reset, saturating.

Behaviour:
- All state updates on the rising edge of clk. Latency is exactly 1 cycle from input to output. There is no combinational path from input to output.
- Per-edge priority is rst > Flush > Stall > load.
- rst=1:
  - Every output goes to 0: ValidOut=0, ALUOpOut=0, FunctOut=0, all control bits 0, all data 0, RdOut=0.
  - BubbleCount=0.
  - Reset asserted mid-stall or mid-flush wins unconditionally.
- Flush=1 (rst=0):
  - Bubble loaded: ValidOut=0, ALUOpOut=0, FunctOut=0, RegWriteOut=0, MemReadOut=0, MemWriteOut=0, MemToRegOut=0.
  - Data fields and RdOut are cleared to 0.
  - Flush overrides a simultaneous Stall.
  - BubbleCount increments by 1, saturating at 255.
- Stall=1, Flush=0:
  - All outputs hold their previous values, including a held bubble.
  - BubbleCount is unchanged.
  - A stall of any length is allowed. Releasing it loads the input present on the release edge.
- Normal:
  - Every output takes its matching input.
  - If ValidIn=0, the control fields are forced to bubble values while the data fields pass through. This counts as a bubble: BubbleCount increments.
- Invariant: when ValidOut=0, RegWriteOut=MemReadOut=MemWriteOut=0.
- Inputs are only sampled, never combinationally forwarded.

Decomposition:
- Shared package pipeline_pkg holds:
  - FUNCT_W and DATA_W defaults.
  - Funct encodings: LOAD=3'b001, STORE=3'b010, ADD=3'b011, NOT=3'b100.
  - A bubble control constant (all-zero control bundle).
- One natural sub-module: pipe_field_reg. It is a parameterised-width register with synchronous clear, clear value, and enable. It is instantiated once for the control bundle and once for the data bundle.
- The saturating counter lives in the top module.

Test Plan:
- Reset:
  - Stimulus: drive every input to non-zero (ALUOpIn=1, FunctIn=3'b011, ReadData1In=16'hABCD) with rst=1 for 2 cycles.
  - Required: all outputs 0, BubbleCount=0.
- Pass-through:
  - Stimulus: rst=0, ValidIn=1, ALUOpIn=1, FunctIn=3'b001, MemReadIn=1, ImmIn=16'h0004, RdIn=3'd5.
  - Required: next cycle shows identical outputs and ValidOut=1.
  - Then change the inputs. Required: outputs follow 1 cycle later.
- Stall:
  - Stimulus: load FunctIn=3'b010 with MemWriteIn=1, then Stall=1 for 3 cycles while inputs change to FunctIn=3'b100.
  - Required: outputs stay at 3'b010 with MemWriteOut=1.
  - Release the stall. Required: the next edge shows 3'b100.
- Flush vs stall:
  - Stimulus: Stall=1 and Flush=1 together while holding a valid store.
  - Required: next cycle ValidOut=0, ALUOpOut=0, MemWriteOut=0, BubbleCount incremented by 1.
- Invalid input:
  - Stimulus: ValidIn=0 with RegWriteIn=1 and ReadData2In=16'h1234.
  - Required: RegWriteOut=0, ALUOpOut=0, ReadData2Out=16'h1234, BubbleCount incremented.
- Saturation and reset mid-stall:
  - Stimulus: 300 consecutive flushes.
  - Required: BubbleCount=255.
  - Then assert rst during a stall. Required: all outputs 0 and BubbleCount=0 on the next edge.
